// File: rtl/fp_addsub_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with round-to-nearest-even,
// subnormal support and a global stall enable driven by the output handshake.
module fp_addsub_pipe #(
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10,
    localparam int unsigned W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         ovf,
    output logic         zero,
    output logic         nan,
    output logic         inexact
);

    localparam int unsigned SW  = MAN_W + 1;     // significand incl. hidden bit
    localparam int unsigned N   = MAN_W + 4;     // significand + G, R, S
    localparam int unsigned EW1 = EXP_W + 1;     // exponent with headroom for carries
    localparam int unsigned WW  = 2 * SW + 2;    // alignment window
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W - 1){1'b0}}};

    logic en;
    logic v1_q, v2_q, v3_q;

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en        = ~v3_q | out_ready;
    assign in_ready  = en;
    assign out_valid = v3_q;

    // ---------------- S1: classify, swap, align ----------------
    logic             sa, sb, a_nan, b_nan, a_inf, b_inf, a_ge;
    logic [EXP_W-1:0] ea, eb, a_eff, b_eff, big_e, sml_e, diff;
    logic [SW-1:0]    a_sig, b_sig, big_sig, sml_sig;
    logic [WW-1:0]    wide, shifted;
    logic [SW+1:0]    al;
    logic             st, big_s, sp1, spnan1;
    logic [W-1:0]     spres1;

    // Operand classification, magnitude ordering and right-shift alignment
    always_comb begin
        sa      = a[W-1];
        sb      = b[W-1] ^ sub;
        ea      = a[W-2:MAN_W];
        eb      = b[W-2:MAN_W];
        a_nan   = (&ea) & (|a[MAN_W-1:0]);
        b_nan   = (&eb) & (|b[MAN_W-1:0]);
        a_inf   = (&ea) & ~(|a[MAN_W-1:0]);
        b_inf   = (&eb) & ~(|b[MAN_W-1:0]);
        a_eff   = (ea == '0) ? EXP_W'(1) : ea;
        b_eff   = (eb == '0) ? EXP_W'(1) : eb;
        a_sig   = {|ea, a[MAN_W-1:0]};
        b_sig   = {|eb, b[MAN_W-1:0]};
        a_ge    = a[W-2:0] >= b[W-2:0];
        big_s   = a_ge ? sa : sb;
        big_e   = a_ge ? a_eff : b_eff;
        big_sig = a_ge ? a_sig : b_sig;
        sml_e   = a_ge ? b_eff : a_eff;
        sml_sig = a_ge ? b_sig : a_sig;
        diff    = big_e - sml_e;
        wide    = {sml_sig, {(SW + 2){1'b0}}};
        shifted = wide >> diff;
        if (32'(diff) >= MAN_W + 3) begin
            al = '0;
            st = |sml_sig;
        end else begin
            al = shifted[WW-1 -: SW+2];
            st = |shifted[SW-1:0];
        end
        sp1    = a_nan | b_nan | a_inf | b_inf;
        spnan1 = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
        if (spnan1) begin
            spres1 = QNAN;
        end else if (a_inf) begin
            spres1 = {sa, EMAX, {MAN_W{1'b0}}};
        end else begin
            spres1 = {sb, EMAX, {MAN_W{1'b0}}};
        end
    end

    logic             s1_sign_q, s1_sub_q, s1_sp_q, s1_spnan_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [SW-1:0]    s1_big_q;
    logic [N-1:0]     s1_sml_q;
    logic [W-1:0]     s1_spres_q;

    // S1 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q       <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_sub_q   <= 1'b0;
            s1_sp_q    <= 1'b0;
            s1_spnan_q <= 1'b0;
            s1_exp_q   <= '0;
            s1_big_q   <= '0;
            s1_sml_q   <= '0;
            s1_spres_q <= '0;
        end else if (en) begin
            v1_q       <= in_valid;
            s1_sign_q  <= big_s;
            s1_sub_q   <= sa ^ sb;
            s1_sp_q    <= sp1;
            s1_spnan_q <= spnan1;
            s1_exp_q   <= big_e;
            s1_big_q   <= big_sig;
            s1_sml_q   <= {al, st};
            s1_spres_q <= spres1;
        end
    end

    // ---------------- S2: add/subtract and normalise ----------------
    logic [N-1:0]   big_ext, man2;
    logic [N:0]     sum;
    logic [EW1-1:0] exp2;
    int unsigned    lz, emin1, sh;
    logic           zero2, sign2;

    // Magnitude add/sub, then carry renormalise or left-normalise clamped at exponent 1
    always_comb begin
        big_ext = {s1_big_q, 3'b000};
        if (s1_sub_q) begin
            sum = {1'b0, big_ext} - {1'b0, s1_sml_q};
        end else begin
            sum = {1'b0, big_ext} + {1'b0, s1_sml_q};
        end
        lz = N;
        for (int unsigned i = 0; i < N; i++) begin
            if (sum[i]) begin
                lz = N - 1 - i;
            end
        end
        emin1 = 32'(s1_exp_q) - 1;
        sh    = (lz > emin1) ? emin1 : lz;
        if (sum[N]) begin
            man2 = {sum[N:2], sum[1] | sum[0]};
            exp2 = {1'b0, s1_exp_q} + EW1'(1);
        end else begin
            man2 = sum[N-1:0] << sh;
            exp2 = {1'b0, s1_exp_q} - EW1'(sh);
        end
        zero2 = ~(|sum);
        // Exact cancellation of opposite signs yields +0
        sign2 = (zero2 && s1_sub_q) ? 1'b0 : s1_sign_q;
    end

    logic           s2_sign_q, s2_zero_q, s2_sp_q, s2_spnan_q;
    logic [EW1-1:0] s2_exp_q;
    logic [N-1:0]   s2_man_q;
    logic [W-1:0]   s2_spres_q;

    // S2 pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_q       <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_sp_q    <= 1'b0;
            s2_spnan_q <= 1'b0;
            s2_exp_q   <= '0;
            s2_man_q   <= '0;
            s2_spres_q <= '0;
        end else if (en) begin
            v2_q       <= v1_q;
            s2_sign_q  <= sign2;
            s2_zero_q  <= zero2;
            s2_sp_q    <= s1_sp_q;
            s2_spnan_q <= s1_spnan_q;
            s2_exp_q   <= exp2;
            s2_man_q   <= man2;
            s2_spres_q <= s1_spres_q;
        end
    end

    // ---------------- S3: round and pack ----------------
    logic           up;
    logic [SW:0]    rsig;
    logic [SW-1:0]  fsig;
    logic [EW1-1:0] fexp;
    logic [W-1:0]   res_d;
    logic           ovf_d, zero_d, nan_d, inex_d;

    // Round-to-nearest-even, overflow to infinity, special-case override
    always_comb begin
        res_d  = '0;
        ovf_d  = 1'b0;
        zero_d = 1'b0;
        nan_d  = 1'b0;
        inex_d = 1'b0;
        up     = s2_man_q[2] & (s2_man_q[1] | s2_man_q[0] | s2_man_q[3]);
        rsig   = {1'b0, s2_man_q[N-1:3]} + {{SW{1'b0}}, up};
        if (rsig[SW]) begin
            fsig = rsig[SW:1];
            fexp = s2_exp_q + EW1'(1);
        end else begin
            fsig = rsig[SW-1:0];
            fexp = s2_exp_q;
        end
        if (s2_sp_q) begin
            res_d = s2_spres_q;
            nan_d = s2_spnan_q;
        end else if (s2_zero_q) begin
            res_d  = {s2_sign_q, {(W - 1){1'b0}}};
            zero_d = 1'b1;
        end else if (fexp >= {1'b0, EMAX}) begin
            res_d  = {s2_sign_q, EMAX, {MAN_W{1'b0}}};
            ovf_d  = 1'b1;
            inex_d = 1'b1;
        end else begin
            // Hidden bit clear means subnormal: exponent field encodes as 0
            res_d  = {s2_sign_q, fsig[MAN_W] ? fexp[EXP_W-1:0] : {EXP_W{1'b0}},
                      fsig[MAN_W-1:0]};
            inex_d = |s2_man_q[2:0];
        end
    end

    logic [W-1:0] res_q;
    logic         ovf_q, zero_q, nan_q, inex_q;

    // Output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_q   <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            nan_q  <= 1'b0;
            inex_q <= 1'b0;
        end else if (en) begin
            v3_q   <= v2_q;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            nan_q  <= nan_d;
            inex_q <= inex_d;
        end
    end

    assign result  = res_q;
    assign ovf     = ovf_q;
    assign zero    = zero_q;
    assign nan     = nan_q;
    assign inexact = inex_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Self-checking bench for fp_addsub_pipe: directed vectors with literal expectations,
// then a random stream under toggling back-pressure and a mid-stream reset,
// all checked through an in-order scoreboard.
module tb_fp_addsub_pipe;

    localparam int unsigned EXP_W = 5;
    localparam int unsigned MAN_W = 10;
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int          EMAXI = (1 << EXP_W) - 1;
    localparam logic [EXP_W-1:0] EMAXV = '1;
    localparam logic [W-1:0]     QNAN  = {1'b0, EMAXV, 1'b1, {(MAN_W - 1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, sub, out_valid, out_ready;
    logic [W-1:0] a, b, result;
    logic         ovf, zero, nan, inexact;

    logic [W+3:0] exp_q[$];
    logic [W+3:0] cur_exp;
    logic         tog;
    int           n_vec = 0;
    int           n_err = 0;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .ovf      (ovf),
        .zero     (zero),
        .nan      (nan),
        .inexact  (inexact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Exact-integer reference: values in units of the smallest subnormal, then RNE.
    function automatic logic [W+3:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic   sx, sy, nx, ny, ix, iy, sg;
        int     ex, ey, p, sh, e;
        longint mx, my, sum, mag, q, r, half;
        sx = x[W-1];
        sy = y[W-1] ^ s;
        ex = int'(x[W-2:MAN_W]);
        ey = int'(y[W-2:MAN_W]);
        nx = (ex == EMAXI) && (x[MAN_W-1:0] != 0);
        ny = (ey == EMAXI) && (y[MAN_W-1:0] != 0);
        ix = (ex == EMAXI) && (x[MAN_W-1:0] == 0);
        iy = (ey == EMAXI) && (y[MAN_W-1:0] == 0);
        if (nx || ny) return {QNAN, 4'b0010};
        if (ix && iy) return (sx != sy) ? {QNAN, 4'b0010} : {sx, EMAXV, {MAN_W{1'b0}}, 4'b0000};
        if (ix) return {sx, EMAXV, {MAN_W{1'b0}}, 4'b0000};
        if (iy) return {sy, EMAXV, {MAN_W{1'b0}}, 4'b0000};
        mx = longint'(x[MAN_W-1:0]) + ((ex != 0) ? (longint'(1) << MAN_W) : 64'sd0);
        my = longint'(y[MAN_W-1:0]) + ((ey != 0) ? (longint'(1) << MAN_W) : 64'sd0);
        mx = mx << ((ex == 0) ? 0 : ex - 1);
        my = my << ((ey == 0) ? 0 : ey - 1);
        sum = (sx ? -mx : mx) + (sy ? -my : my);
        if (sum == 0) return {((sx == sy) ? sx : 1'b0), {(W - 1){1'b0}}, 4'b0100};
        sg  = sum < 0;
        mag = sg ? -sum : sum;
        p = 0;
        for (int i = 0; i < 62; i++) if (mag[i]) p = i;
        if (p < int'(MAN_W)) return {sg, {EXP_W{1'b0}}, mag[MAN_W-1:0], 4'b0000};
        sh   = p - int'(MAN_W);
        q    = mag >> sh;
        r    = mag - (q << sh);
        half = (sh > 0) ? (longint'(1) << (sh - 1)) : 64'sd0;
        e    = sh + 1;
        if (sh > 0 && (r > half || (r == half && q[0]))) q++;
        if (q >= (longint'(1) << (MAN_W + 1))) begin
            q = q >> 1;
            e++;
        end
        if (e >= EMAXI) return {sg, EMAXV, {MAN_W{1'b0}}, 4'b1001};
        return {sg, e[EXP_W-1:0], q[MAN_W-1:0], 3'b000, (r != 0)};
    endfunction

    // Scoreboard: push on accepted input, compare on every valid output, pop on transfer
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    assert (exp_q.size() != 0) else begin
                        n_err++;
                        $error("FAIL spurious_beat: observed result %h expected no beat", result);
                    end
                end else begin
                    check(out_ready ? "beat" : "stall_hold",
                          32'({result, ovf, zero, nan, inexact}), 32'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) out_ready = ~out_ready;
        #1;
    endtask

    task automatic run_vec(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs,
                           input logic [W+3:0] expv);
        a        = va;
        b        = vb;
        sub      = vs;
        cur_exp  = expv;
        in_valid = 1'b1;
        step();
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) step();
        n_vec++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL drain: observed %0d beats pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        int           lat;
        logic         accepted;
        logic [W-1:0] ra, rb;
        logic         rs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cur_exp   = '0;
        tog       = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 32'({out_valid, in_ready, result, ovf, zero, nan, inexact}),
              32'({1'b0, 1'b1, {W{1'b0}}, 4'b0000}));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Latency of a single beat
        run_vec(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'b0000});
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // Directed vectors, back to back
        run_vec(16'h3C00, 16'h4000, 1'b0, {16'h4200, 4'b0000});
        run_vec(16'h3C00, 16'h3C00, 1'b1, {16'h0000, 4'b0100});
        run_vec(16'h8000, 16'h0000, 1'b1, {16'h8000, 4'b0100});
        run_vec(16'h8000, 16'h8000, 1'b0, {16'h8000, 4'b0100});
        run_vec(16'h3C00, 16'h1000, 1'b0, {16'h3C00, 4'b0001});
        run_vec(16'h3C01, 16'h1000, 1'b0, {16'h3C02, 4'b0001});
        run_vec(16'h7BFF, 16'h7BFF, 1'b0, {16'h7C00, 4'b1001});
        run_vec(16'h7C00, 16'hFC00, 1'b0, {16'h7E00, 4'b0010});
        run_vec(16'h7C00, 16'h7C00, 1'b1, {16'h7E00, 4'b0010});
        run_vec(16'h7C00, 16'h3C00, 1'b0, {16'h7C00, 4'b0000});
        run_vec(16'hFC00, 16'h3C00, 1'b1, {16'hFC00, 4'b0000});
        run_vec(16'h7C01, 16'h3C00, 1'b0, {16'h7E00, 4'b0010});
        run_vec(16'h0001, 16'h0001, 1'b0, {16'h0002, 4'b0000});
        run_vec(16'h03FF, 16'h0001, 1'b0, {16'h0400, 4'b0000});
        run_vec(16'h0400, 16'h0001, 1'b1, {16'h03FF, 4'b0000});
        run_vec(16'h3C00, 16'h4000, 1'b1, {16'hBC00, 4'b0000});
        in_valid = 1'b0;
        drain();

        // Random stream under toggling out_ready, with a reset pulse mid-stream
        tog = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                in_valid = 1'b0;
                rst      = 1'b1;
                @(negedge clk);
                check("rst_flush", 32'(out_valid), 32'd0);
                @(posedge clk);
                #1 rst = 1'b0;
                #1;
            end
            ra = W'($urandom);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) rb = W'($urandom);
            else rb = {1'($urandom_range(0, 1)), ra[W-2:MAN_W], MAN_W'($urandom)};
            a        = ra;
            b        = rb;
            sub      = rs;
            cur_exp  = model(ra, rb, rs);
            in_valid = 1'b1;
            accepted = 1'b0;
            for (int t = 0; t < 20 && !accepted; t++) begin
                accepted = in_ready;
                step();
            end
            n_vec++;
            assert (accepted) else begin
                n_err++;
                $error("FAIL accept_timeout: observed in_ready=0 expected 1 within 20 cycles");
            end
        end
        in_valid = 1'b0;
        drain();
        tog       = 1'b0;
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
